// File: rtl/signed_bcd_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : signed_bcd_decoder_pkg                                 |
// | Description : Shared types and constants for the signed BCD decoder  |
// |               (FSM states, digit-adjust constants, blank code).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package signed_bcd_decoder_pkg;

   // Conversion sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Digit code rendered as blank by the 7-segment driver
   localparam logic [3:0] BCD_BLANK  = 4'hF;

   // Double-dabble digit correction: add ADJ_ADD when digit >= ADJ_THRESH
   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_ADD    = 4'd3;

   // Width needed to hold a shift count from 0 up to w inclusive
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage : signed_bcd_decoder_pkg
`default_nettype wire

// File: rtl/signed_bcd_decoder_bcd_digit_adjust.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_digit_adjust                                       |
// | Description : One double-dabble digit correction: add 3 when the     |
// |               digit is 5 or more, so the following left shift        |
// |               carries correctly into the next decimal digit.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bcd_digit_adjust
   import signed_bcd_decoder_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Digits 5..9 become 8..12 so that doubling overflows into the next digit
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= ADJ_THRESH) begin
         digit_o = digit_i + ADJ_ADD;
      end
   end

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/signed_bcd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : signed_bcd_decoder                                     |
// | Description : Two's-complement to sign + packed BCD magnitude, using |
// |               a sequential double-dabble engine with start/busy/done |
// |               handshake. Optional build macro LEADING_ZERO_BLANK_EN  |
// |               replaces leading zero digits (above the LSD) by 4'hF.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module signed_bcd_decoder
   import signed_bcd_decoder_pkg::*;
#(
   parameter int W      = 8,
   parameter int DIGITS = 3
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [W-1:0]        din,
   output logic                busy,
   output logic                done,
   output logic                sign,
   output logic [4*DIGITS-1:0] bcd
);

   localparam int CW = cnt_width(W);
   localparam int BW = 4 * DIGITS;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     scratch_q, scratch_d;
   logic [W-1:0]      mag_q, mag_d;
   logic              neg_q, neg_d;
   logic              sign_q, sign_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              done_q, done_d;

   logic [BW-1:0]     adj_w;
   logic [BW-1:0]     bcd_fmt_w;

   // Per-digit correction applied to the scratch register before each shift
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adjust u_adj (
            .digit_i (scratch_q[4*gi +: 4]),
            .digit_o (adj_w[4*gi +: 4])
         );
      end
   endgenerate

   // Final digit formatting: optional blanking of leading zeros (LSD kept)
`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic lead;
      bcd_fmt_w = scratch_q;
      lead      = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (scratch_q[4*i +: 4] == 4'd0)) begin
            bcd_fmt_w[4*i +: 4] = BCD_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   always_comb begin
      bcd_fmt_w = scratch_q;
   end
`endif

   // State and datapath registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         scratch_q <= '0;
         mag_q     <= '0;
         neg_q     <= 1'b0;
         sign_q    <= 1'b0;
         bcd_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         scratch_q <= scratch_d;
         mag_q     <= mag_d;
         neg_q     <= neg_d;
         sign_q    <= sign_d;
         bcd_q     <= bcd_d;
         done_q    <= done_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      scratch_d = scratch_q;
      mag_d     = mag_q;
      neg_d     = neg_q;
      sign_d    = sign_q;
      bcd_d     = bcd_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // A start coinciding with the done pulse belongs to the finished
            // transfer's handshake window and is deliberately dropped.
            if (start && !done_q) begin
               neg_d     = din[W-1];
               mag_d     = din[W-1] ? ((~din) + W'(1)) : din;
               scratch_d = '0;
               cnt_d     = CW'(W);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_d, mag_d} = {adj_w, mag_q} << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = bcd_fmt_w;
            sign_d  = neg_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign sign = sign_q;
   assign bcd  = bcd_q;

endmodule : signed_bcd_decoder
`default_nettype wire
